// File: rtl/urna_generica_if.sv
// Booth interface: keypad/control strobes toward the urn and the
// registered tallies/status coming back.
//   master : drives Digit, Valid, Cancel, Confirm, Finish
//   slave  : the urn; drives Counts, Nulo, Total, Match, DigCount,
//            Status, Overflow
interface urna_generica_if #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8
);
  logic [3:0]              Digit;
  logic                    Valid;
  logic                    Cancel;
  logic                    Confirm;
  logic                    Finish;
  logic [N_CAND*CNT_W-1:0] Counts;
  logic [CNT_W-1:0]        Nulo;
  logic [CNT_W+3:0]        Total;
  logic [N_CAND-1:0]       Match;
  logic [3:0]              DigCount;
  logic                    Status;
  logic                    Overflow;

  modport master (
    output Digit, Valid, Cancel, Confirm, Finish,
    input  Counts, Nulo, Total, Match, DigCount, Status, Overflow
  );

  modport slave (
    input  Digit, Valid, Cancel, Confirm, Finish,
    output Counts, Nulo, Total, Match, DigCount, Status, Overflow
  );
endinterface

// File: rtl/urna_generica.sv
// Generic electronic ballot box. A voter types N_DIG BCD digits, reviews the
// matched candidate, confirms, and the booth stays locked until Finish.
// Ports:
//   Clock  : sole clock, rising edge
//   Reset  : synchronous, active-high; clears tallies and returns to ENTRY
//   bus    : urna_generica_if.slave (digit strobes in, tallies/status out)
//
// state  | meaning
// ENTRY  | collecting digits, DigCount counts them
// REVIEW | all digits typed, Match shows the candidate, awaiting Confirm
// VOTED  | vote committed, Status=1, only Finish (or Reset) releases
module urna_generica #(
  parameter int N_CAND = 4,
  parameter int N_DIG  = 4,
  parameter int CNT_W  = 8,
  parameter logic [N_CAND*N_DIG*4-1:0] CODES =
    {16'h3504, 16'h3472, 16'h3485, 16'h3494}
) (
  input logic           Clock,
  input logic           Reset,
  urna_generica_if.slave bus
);
  localparam int         DW   = N_DIG * 4;
  localparam logic [3:0] LAST = 4'(N_DIG - 1);

  typedef enum logic [1:0] {ENTRY, REVIEW, VOTED} state_t;

  state_t            state;
  logic [DW-1:0]     digits;
  logic [3:0]        dig_count;
  logic [N_CAND-1:0] match;
  logic [CNT_W-1:0]  tally [N_CAND];
  logic [CNT_W-1:0]  nulo;
  logic [CNT_W+3:0]  total;
  logic              status;
  logic              overflow;

  logic [DW-1:0]     next_digits;
  logic [N_CAND-1:0] match_next;
  logic              all_bcd;
  logic              found;

  // Candidate lookup on the digit string as it will be after this strobe,
  // so Match is ready in the same edge that enters REVIEW. Any non-BCD
  // digit forces a null vote; the lowest index wins on duplicate codes.
  always_comb begin
    next_digits = (digits << 4) | DW'(bus.Digit);
    all_bcd     = 1'b1;
    for (int k = 0; k < N_DIG; k++)
      if (next_digits[k*4 +: 4] > 4'd9) all_bcd = 1'b0;
    match_next = '0;
    found      = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      if (!found && all_bcd && next_digits == CODES[i*DW +: DW]) begin
        match_next[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ENTRY;
      digits    <= '0;
      dig_count <= '0;
      match     <= '0;
      for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
      nulo      <= '0;
      total     <= '0;
      status    <= 1'b0;
      overflow  <= 1'b0;
    end else if (bus.Finish || (bus.Cancel && state != VOTED)) begin
      state     <= ENTRY;
      digits    <= '0;
      dig_count <= '0;
      match     <= '0;
      status    <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (bus.Valid) begin
            digits    <= next_digits;
            dig_count <= dig_count + 4'd1;
            if (dig_count == LAST) begin
              state <= REVIEW;
              match <= match_next;
            end
          end
        end
        REVIEW: begin
          if (bus.Confirm) begin
            // Counters saturate; a blocked increment latches Overflow.
            if (match == '0) begin
              if (nulo == '1) overflow <= 1'b1;
              else            nulo     <= nulo + 1'b1;
            end else begin
              for (int i = 0; i < N_CAND; i++) begin
                if (match[i]) begin
                  if (tally[i] == '1) overflow <= 1'b1;
                  else                tally[i] <= tally[i] + 1'b1;
                end
              end
            end
            if (total == '1) overflow <= 1'b1;
            else             total    <= total + 1'b1;
            status <= 1'b1;
            match  <= '0;
            state  <= VOTED;
          end
        end
        VOTED:   ;
        default: state <= ENTRY;
      endcase
    end
  end

  for (genvar g = 0; g < N_CAND; g++) begin : g_pack
    assign bus.Counts[g*CNT_W +: CNT_W] = tally[g];
  end

  assign bus.Nulo     = nulo;
  assign bus.Total    = total;
  assign bus.Match    = match;
  assign bus.DigCount = dig_count;
  assign bus.Status   = status;
  assign bus.Overflow = overflow;
endmodule

// File: tb/tb_urna_generica.sv
module tb_urna_generica;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] digit = '0;
  logic       valid = 1'b0, cancel = 1'b0, confirm = 1'b0, finish = 1'b0;

  always #5 Clock = ~Clock;

  urna_generica_if #(.N_CAND(4), .CNT_W(8)) b1 ();
  urna_generica_if #(.N_CAND(4), .CNT_W(2)) b2 ();

  assign b1.Digit = digit;  assign b2.Digit = digit;
  assign b1.Valid = valid;  assign b2.Valid = valid;
  assign b1.Cancel = cancel;  assign b2.Cancel = cancel;
  assign b1.Confirm = confirm; assign b2.Confirm = confirm;
  assign b1.Finish = finish;  assign b2.Finish = finish;

  urna_generica #(.CNT_W(8)) dut1 (.Clock(Clock), .Reset(Reset), .bus(b1));
  urna_generica #(.CNT_W(2)) dut2 (.Clock(Clock), .Reset(Reset), .bus(b2));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: typed digits as a list, tallies as unbounded integers;
  // saturation and overflow are derived when the outputs are predicted.
  int code_tab [4] = '{'h3494, 'h3485, 'h3472, 'h3504};
  int typed[$];
  bit locked = 1'b0;
  int raw_cnt [4] = '{0, 0, 0, 0};
  int raw_nulo = 0;
  int raw_tot  = 0;

  function automatic int lookup();
    int value = 0;
    foreach (typed[k]) begin
      if (typed[k] > 9) return -1;
      value = value * 16 + typed[k];
    end
    for (int i = 0; i < 4; i++) if (code_tab[i] == value) return i;
    return -1;
  endfunction

  function automatic int sat(int raw, int maxv);
    return (raw > maxv) ? maxv : raw;
  endfunction

  task automatic model_step(bit r, int d, bit v, bit can, bit con, bit fin);
    int c;
    if (r) begin
      typed.delete(); locked = 1'b0;
      for (int i = 0; i < 4; i++) raw_cnt[i] = 0;
      raw_nulo = 0; raw_tot = 0;
    end else if (fin) begin
      typed.delete(); locked = 1'b0;
    end else if (locked) begin
    end else if (can) begin
      typed.delete();
    end else if (typed.size() == 4) begin
      if (con) begin
        c = lookup();
        if (c < 0) raw_nulo++;
        else       raw_cnt[c]++;
        raw_tot++;
        locked = 1'b1;
      end
    end else if (v) begin
      typed.push_back(d);
    end
  endtask

  task automatic check_model();
    logic [31:0] ec1;
    logic [7:0]  ec2;
    logic [3:0]  em;
    bit          ov1, ov2;
    int          c;
    em = '0;
    if (!locked && typed.size() == 4) begin
      c = lookup();
      if (c >= 0) em[c] = 1'b1;
    end
    ov1 = (raw_nulo > 255) || (raw_tot > 4095);
    ov2 = (raw_nulo > 3) || (raw_tot > 63);
    for (int i = 0; i < 4; i++) begin
      ec1[i*8 +: 8] = 8'(sat(raw_cnt[i], 255));
      ec2[i*2 +: 2] = 2'(sat(raw_cnt[i], 3));
      if (raw_cnt[i] > 255) ov1 = 1'b1;
      if (raw_cnt[i] > 3)   ov2 = 1'b1;
    end
    vectors++;
    if ({b1.Counts, b1.Nulo, b1.Total, b1.Match, b1.DigCount, b1.Status, b1.Overflow} !==
        {ec1, 8'(sat(raw_nulo, 255)), 12'(sat(raw_tot, 4095)), em, 4'(typed.size()), locked, ov1}) begin
      miscompares++;
      $display("FAIL model_w8 t=%0t got counts=%h nulo=%0d total=%0d match=%b dc=%0d st=%b ov=%b want counts=%h nulo=%0d total=%0d match=%b dc=%0d st=%b ov=%b",
               $time, b1.Counts, b1.Nulo, b1.Total, b1.Match, b1.DigCount, b1.Status, b1.Overflow,
               ec1, sat(raw_nulo, 255), sat(raw_tot, 4095), em, typed.size(), locked, ov1);
    end
    vectors++;
    if ({b2.Counts, b2.Nulo, b2.Total, b2.Match, b2.DigCount, b2.Status, b2.Overflow} !==
        {ec2, 2'(sat(raw_nulo, 3)), 6'(sat(raw_tot, 63)), em, 4'(typed.size()), locked, ov2}) begin
      miscompares++;
      $display("FAIL model_w2 t=%0t got counts=%h nulo=%0d total=%0d match=%b dc=%0d st=%b ov=%b want counts=%h nulo=%0d total=%0d match=%b dc=%0d st=%b ov=%b",
               $time, b2.Counts, b2.Nulo, b2.Total, b2.Match, b2.DigCount, b2.Status, b2.Overflow,
               ec2, sat(raw_nulo, 3), sat(raw_tot, 63), em, typed.size(), locked, ov2);
    end
  endtask

  task automatic apply(bit r, int d, bit v, bit can, bit con, bit fin);
    Reset = r; digit = 4'(d); valid = v; cancel = can; confirm = con; finish = fin;
    @(posedge Clock);
    model_step(r, d, v, can, con, fin);
    @(negedge Clock);
    check_model();
  endtask

  task automatic check_val(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct {
    bit r; int d; bit v, can, con, fin;
    logic [3:0] m; int dc; bit st; int tot; int nul;
  } vec_t;

  function automatic vec_t mk(bit r, int d, bit v, bit can, bit con, bit fin,
                              logic [3:0] m, int dc, bit st, int tot, int nul);
    vec_t x;
    x.r = r; x.d = d; x.v = v; x.can = can; x.con = con; x.fin = fin;
    x.m = m; x.dc = dc; x.st = st; x.tot = tot; x.nul = nul;
    return x;
  endfunction

  vec_t tab[$];

  initial begin
    int cand;
    int pos;
    int d;
    //              r  d   v can con fin   match  dc st tot nul
    tab.push_back(mk(1, 0,  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 0, 0));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0000, 2, 0, 0, 0));
    tab.push_back(mk(0, 9,  1, 0, 0, 0, 4'b0000, 3, 0, 0, 0));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0001, 4, 0, 0, 0));
    tab.push_back(mk(0, 0,  0, 0, 1, 0, 4'b0000, 4, 1, 1, 0));
    tab.push_back(mk(0, 0,  0, 0, 0, 1, 4'b0000, 0, 0, 1, 0));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 1, 0));
    tab.push_back(mk(0, 5,  1, 0, 0, 0, 4'b0000, 2, 0, 1, 0));
    tab.push_back(mk(0, 0,  1, 0, 0, 0, 4'b0000, 3, 0, 1, 0));
    tab.push_back(mk(0, 1,  1, 0, 0, 0, 4'b0000, 4, 0, 1, 0));
    tab.push_back(mk(0, 0,  0, 0, 1, 0, 4'b0000, 4, 1, 2, 1));
    tab.push_back(mk(0, 0,  0, 0, 0, 1, 4'b0000, 0, 0, 2, 1));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 2, 1));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0000, 2, 0, 2, 1));
    tab.push_back(mk(0, 0,  0, 1, 0, 0, 4'b0000, 0, 0, 2, 1));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 2, 1));
    tab.push_back(mk(0, 5,  1, 0, 0, 0, 4'b0000, 2, 0, 2, 1));
    tab.push_back(mk(0, 0,  1, 0, 0, 0, 4'b0000, 3, 0, 2, 1));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b1000, 4, 0, 2, 1));
    tab.push_back(mk(0, 0,  0, 0, 1, 0, 4'b0000, 4, 1, 3, 1));
    tab.push_back(mk(0, 7,  1, 1, 1, 0, 4'b0000, 4, 1, 3, 1));
    tab.push_back(mk(0, 0,  0, 0, 0, 1, 4'b0000, 0, 0, 3, 1));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 3, 1));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0000, 2, 0, 3, 1));
    tab.push_back(mk(0, 8,  1, 0, 0, 0, 4'b0000, 3, 0, 3, 1));
    tab.push_back(mk(0, 5,  1, 0, 0, 0, 4'b0010, 4, 0, 3, 1));
    tab.push_back(mk(0, 0,  0, 0, 1, 0, 4'b0000, 4, 1, 4, 1));
    tab.push_back(mk(0, 0,  0, 0, 0, 1, 4'b0000, 0, 0, 4, 1));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 4, 1));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0000, 2, 0, 4, 1));
    tab.push_back(mk(0, 8,  1, 0, 0, 0, 4'b0000, 3, 0, 4, 1));
    tab.push_back(mk(1, 0,  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    tab.push_back(mk(0, 3,  1, 0, 1, 0, 4'b0000, 1, 0, 0, 0));
    tab.push_back(mk(0, 10, 1, 0, 0, 0, 4'b0000, 2, 0, 0, 0));
    tab.push_back(mk(0, 9,  1, 0, 0, 0, 4'b0000, 3, 0, 0, 0));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0000, 4, 0, 0, 0));
    tab.push_back(mk(0, 0,  0, 0, 1, 0, 4'b0000, 4, 1, 1, 1));
    tab.push_back(mk(0, 0,  0, 0, 0, 1, 4'b0000, 0, 0, 1, 1));
    tab.push_back(mk(0, 3,  1, 0, 0, 0, 4'b0000, 1, 0, 1, 1));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0000, 2, 0, 1, 1));
    tab.push_back(mk(0, 9,  1, 0, 0, 0, 4'b0000, 3, 0, 1, 1));
    tab.push_back(mk(0, 4,  1, 0, 0, 0, 4'b0001, 4, 0, 1, 1));
    tab.push_back(mk(0, 0,  0, 1, 1, 1, 4'b0000, 0, 0, 1, 1));
    tab.push_back(mk(0, 0,  0, 1, 1, 0, 4'b0000, 0, 0, 1, 1));

    foreach (tab[i]) begin
      apply(tab[i].r, tab[i].d, tab[i].v, tab[i].can, tab[i].con, tab[i].fin);
      vectors++;
      if (b1.Match !== tab[i].m || int'(b1.DigCount) != tab[i].dc || b1.Status !== tab[i].st ||
          int'(b1.Total) != tab[i].tot || int'(b1.Nulo) != tab[i].nul) begin
        miscompares++;
        $display("FAIL table[%0d] got match=%b dc=%0d st=%b tot=%0d nulo=%0d want match=%b dc=%0d st=%b tot=%0d nulo=%0d",
                 i, b1.Match, b1.DigCount, b1.Status, b1.Total, b1.Nulo,
                 tab[i].m, tab[i].dc, tab[i].st, tab[i].tot, tab[i].nul);
      end
    end

    // Saturation: five votes for 3472 on the 2-bit instance, Confirm held twice.
    apply(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      apply(0, 3, 1, 0, 0, 0);
      apply(0, 4, 1, 0, 0, 0);
      apply(0, 7, 1, 0, 0, 0);
      apply(0, 2, 1, 0, 0, 0);
      apply(0, 0, 0, 0, 1, 0);
      apply(0, 0, 0, 0, 1, 0);
      apply(0, 0, 0, 0, 0, 1);
    end
    check_val("w2_slice2", int'(b2.Counts[5:4]), 3);
    check_val("w2_total", int'(b2.Total), 5);
    check_val("w2_overflow", int'(b2.Overflow), 1);
    check_val("w8_slice2", int'(b1.Counts[23:16]), 5);
    check_val("w8_overflow", int'(b1.Overflow), 0);

    // Random traffic, digits biased toward the candidate codes.
    apply(1, 0, 0, 0, 0, 0);
    cand = 0;
    for (int n = 0; n < 600; n++) begin
      pos = typed.size();
      if (pos == 0) cand = $urandom_range(0, 3);
      if (pos < 4 && $urandom_range(0, 4) != 0)
        d = (code_tab[cand] >> (4 * (3 - pos))) & 15;
      else
        d = $urandom_range(0, 15);
      apply($urandom_range(0, 99) == 0, d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/urna_generica.md
URNA_GENERICA -- requirements
Module: urna_generica

Interface
REQ-001 SHALL have parameter N_CAND, default 4: number of candidates, 1..16.
REQ-002 SHALL have parameter N_DIG, default 4: BCD digits per vote code, 1..8.
REQ-003 SHALL have parameter CNT_W, default 8: width of each tally counter.
REQ-004 SHALL have parameter CODES, default {16'h3504,16'h3472,16'h3485,16'h3494}: packed BCD codes, N_CAND*N_DIG*4 bits; candidate i occupies slice i; first-typed digit in the most significant nibble.
REQ-005 SHALL have port Clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Digit  input  4  BCD digit, sampled when Valid=1.
REQ-008 SHALL have port Valid  input  1  one-cycle digit strobe.
REQ-009 SHALL have port Cancel  input  1  discard typed digits.
REQ-010 SHALL have port Confirm  input  1  commit the reviewed vote.
REQ-011 SHALL have port Finish  input  1  release booth for next voter.
REQ-012 SHALL have port Counts  output  N_CAND*CNT_W  packed candidate tallies, candidate i at slice i.
REQ-013 SHALL have port Nulo  output  CNT_W  null-vote tally.
REQ-014 SHALL have port Total  output  CNT_W+4  all committed votes.
REQ-015 SHALL have port Match  output  N_CAND  one-hot preview of matched candidate.
REQ-016 SHALL have port DigCount  output  4  digits typed so far.
REQ-017 SHALL have port Status  output  1  vote committed, booth locked.
REQ-018 SHALL have port Overflow  output  1  sticky: some counter saturated.

Function
REQ-019 SHALL implement states ENTRY, REVIEW, VOTED; all outputs registered.
REQ-020 ENTRY: Valid=1 SHALL shift Digit into the digit register and increment DigCount; on the N_DIG-th digit go to REVIEW next cycle.
REQ-021 Digits >9 SHALL be accepted and SHALL make the vote null.
REQ-022 On entering REVIEW, Match SHALL show the bit of the candidate whose code equals all typed digits, else all zero; Match SHALL be zero outside REVIEW.
REQ-023 REVIEW: Valid SHALL be ignored; Confirm=1 SHALL increment the matching Counts slice, or Nulo if Match is zero, increment Total, set Status=1, go to VOTED; 1-cycle latency.
REQ-024 Cancel=1 in ENTRY or REVIEW SHALL clear DigCount and the digit register and return to ENTRY; tallies unchanged.
REQ-025 VOTED: Valid, Confirm and Cancel SHALL be ignored; Finish=1 SHALL clear Status, DigCount and the digit register and go to ENTRY.
REQ-026 Finish in ENTRY or REVIEW SHALL act as Cancel.
REQ-027 Priority per cycle: Reset > Finish > Cancel > Confirm > Valid.
REQ-028 Exactly one counter plus Total SHALL change per committed vote.
REQ-029 Every counter SHALL saturate at its all-ones value, never wrap; a saturated increment SHALL set Overflow until Reset.
REQ-030 Duplicate codes in CODES: lowest-index candidate SHALL win.
REQ-031 Confirm held several cycles SHALL commit exactly one vote.

Reset
REQ-032 Reset=1 at a rising edge SHALL zero Counts, Nulo, Total, Match, DigCount, Status, Overflow and the digit register, and force ENTRY, in any state including mid-entry.
REQ-033 Tallies SHALL be cleared only by Reset; Finish SHALL NOT clear them.

Verification
REQ-034 Defaults; digits 3,4,9,4, Confirm -> Match=0001, then Counts slice0=1, Total=1, Status=1.
REQ-035 Digits 3,5,0,1, Confirm -> Match=0000, Nulo=1, Counts all 0.
REQ-036 Digits 3,4, Cancel, digits 3,5,0,4, Confirm -> slice3=1, DigCount=0 after Cancel.
REQ-037 CNT_W=2; five votes for 3472 -> slice2=3, Total=5, Overflow=1.
REQ-038 Digits 3,4,8 then Reset -> all outputs 0, state ENTRY; Valid with Confirm in ENTRY -> digit taken, no vote.
REQ-039 After a vote, Valid and Confirm before Finish -> no change; Finish -> Status=0, new vote accepted.
